// File: rtl/joy_filt_pkg.sv
// Shared types and helpers for the joystick direction conditioner.
// Direction vectors are packed {up, down, left, right}.
package joy_filt_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_LAST = 2'd1,
        MODE_4WAY = 2'd2,
        MODE_2WAY = 2'd3
    } mode_e;

    localparam int DIR_R = 0;
    localparam int DIR_L = 1;
    localparam int DIR_D = 2;
    localparam int DIR_U = 3;

    localparam logic [3:0] DIR_ALL   = 4'hF;
    localparam logic [3:0] DIR_HORIZ = 4'b0011;
    localparam int         MAX_PLAYERS = 4;

    // One-hot of the highest-priority set bit: up > down > left > right.
    function automatic logic [3:0] prio_onehot(input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        if (v[DIR_U])      r[DIR_U] = 1'b1;
        else if (v[DIR_D]) r[DIR_D] = 1'b1;
        else if (v[DIR_L]) r[DIR_L] = 1'b1;
        else if (v[DIR_R]) r[DIR_R] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/joy_filt_chan.sv
// One player's pipeline: 2-flop sync, per-bit debounce, optional SOCD clean, direction filter.
// Build option: JOYFILT_SOCD_EN clears opposite direction pairs held together.
module joy_filt_chan
    import joy_filt_pkg::*;
#(
    parameter int DEB_W     = 8,
    parameter int DEB_TICKS = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic [1:0] i_mode,
    input  logic [3:0] i_dir_in,
    output logic [3:0] o_dir_out,
    output logic       o_changed
);

    if (DEB_TICKS >= (2 ** DEB_W)) begin : g_bad_ticks
        $error("joy_filt_chan: DEB_TICKS must be below 2**DEB_W");
    end

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_deb;
    logic [3:0] w_clean;
    logic [3:0] r_prev;
    logic [3:0] r_mask;
    logic [3:0] r_cur;
    logic [3:0] r_dir_out;
    logic       r_changed;
    mode_e      r_mode;
    mode_e      w_mode;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_dir_in;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_deb
        logic r_deb_bit;

        if (DEB_TICKS == 0) begin : g_bypass
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) r_deb_bit <= 1'b0;
                else            r_deb_bit <= r_sync2[gi];
            end
        end else begin : g_count
            localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);
            logic [DEB_W-1:0] r_cnt;

            // Any bounce back to the accepted level restarts the stability count.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_cnt     <= '0;
                    r_deb_bit <= 1'b0;
                end else if (r_sync2[gi] == r_deb_bit) begin
                    r_cnt <= '0;
                end else if (i_ce) begin
                    if (r_cnt == DEB_LAST) begin
                        r_deb_bit <= r_sync2[gi];
                        r_cnt     <= '0;
                    end else if (r_cnt != {DEB_W{1'b1}}) begin
                        r_cnt <= r_cnt + DEB_W'(1);
                    end
                end
            end
        end

        assign w_deb[gi] = r_deb_bit;
    end

`ifdef JOYFILT_SOCD_EN
    always_comb begin
        w_clean = w_deb;
        if (w_deb[DIR_L] && w_deb[DIR_R]) begin
            w_clean[DIR_L] = 1'b0;
            w_clean[DIR_R] = 1'b0;
        end
        if (w_deb[DIR_U] && w_deb[DIR_D]) begin
            w_clean[DIR_U] = 1'b0;
            w_clean[DIR_D] = 1'b0;
        end
    end
`else
    assign w_clean = w_deb;
`endif

    logic [3:0] w_new;
    logic [3:0] w_lim;
    logic [3:0] w_lim_new;
    logic [3:0] w_mask_next;
    logic [3:0] w_cur_next;
    logic [3:0] w_out_next;

    assign w_mode = mode_e'(i_mode);

    // On a mode switch only the tracking state is cleared; the output holds one cycle.
    always_comb begin
        w_new       = w_clean & ~r_prev;
        w_lim       = (w_mode == MODE_2WAY) ? (w_clean & DIR_HORIZ) : w_clean;
        w_lim_new   = w_lim & ~r_prev;
        w_mask_next = r_mask;
        w_cur_next  = r_cur;
        w_out_next  = r_dir_out;
        if (w_mode != r_mode) begin
            w_mask_next = DIR_ALL;
            w_cur_next  = '0;
        end else begin
            case (w_mode)
                MODE_PASS: begin
                    w_out_next = w_clean;
                end
                MODE_LAST: begin
                    if (|w_new)
                        w_mask_next = prio_onehot(w_new);
                    if ((w_clean & r_mask) == 4'd0)
                        w_mask_next = DIR_ALL;
                    w_out_next = w_clean & w_mask_next;
                end
                MODE_4WAY, MODE_2WAY: begin
                    if (|(w_lim & r_cur)) begin
                        if (|w_lim_new)
                            w_cur_next = prio_onehot(w_lim_new);
                    end else begin
                        w_cur_next = prio_onehot(w_lim);
                    end
                    w_out_next = w_cur_next;
                end
                default: w_out_next = r_dir_out;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev    <= '0;
            r_mask    <= DIR_ALL;
            r_cur     <= '0;
            r_mode    <= MODE_PASS;
            r_dir_out <= '0;
            r_changed <= 1'b0;
        end else begin
            r_prev    <= w_clean;
            r_mask    <= w_mask_next;
            r_cur     <= w_cur_next;
            r_mode    <= w_mode;
            r_dir_out <= w_out_next;
            r_changed <= (w_out_next != r_dir_out);
        end
    end

    assign o_dir_out = r_dir_out;
    assign o_changed = r_changed;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner: one independent joy_filt_chan per player.
// Build option: JOYFILT_SOCD_EN (opposite-pair cleaning inside each channel).
module joy_dir_filter
    import joy_filt_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DEB_W       = 8,
    parameter int DEB_TICKS   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_ce,
    input  logic [2*NUM_PLAYERS-1:0] i_mode,
    input  logic [4*NUM_PLAYERS-1:0] i_dir_in,
    output logic [4*NUM_PLAYERS-1:0] o_dir_out,
    output logic [NUM_PLAYERS-1:0]   o_changed
);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > MAX_PLAYERS) begin : g_bad_players
        $error("joy_dir_filter: NUM_PLAYERS out of range");
    end

    genvar gi;
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        joy_filt_chan #(
            .DEB_W     (DEB_W),
            .DEB_TICKS (DEB_TICKS)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_ce      (i_ce),
            .i_mode    (i_mode[2*gi +: 2]),
            .i_dir_in  (i_dir_in[4*gi +: 4]),
            .o_dir_out (o_dir_out[4*gi +: 4]),
            .o_changed (o_changed[gi])
        );
    end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Self-checking bench: two instances (debounce bypassed / DEB_TICKS=4) against a behavioural model.
module tb_joy_dir_filter;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [3:0] mode;
    logic [7:0] dir_in;
    logic [7:0] out_fast, out_deb;
    logic [1:0] chg_fast, chg_deb;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_p0  = 0;

    joy_dir_filter #(.NUM_PLAYERS(2), .DEB_W(8), .DEB_TICKS(0)) u_dut_fast (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_mode(mode),
        .i_dir_in(dir_in), .o_dir_out(out_fast), .o_changed(chg_fast)
    );

    joy_dir_filter #(.NUM_PLAYERS(2), .DEB_W(8), .DEB_TICKS(4)) u_dut_deb (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_mode(mode),
        .i_dir_in(dir_in), .o_dir_out(out_deb), .o_changed(chg_deb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state, indexed [instance][player]; instance 0 has no debounce, 1 needs 4 ticks.
    logic [3:0] m_s1   [2][2];
    logic [3:0] m_s2   [2][2];
    logic [3:0] m_deb  [2][2];
    logic [3:0] m_prev [2][2];
    logic [3:0] m_mask [2][2];
    logic [3:0] m_cur  [2][2];
    logic [3:0] m_out  [2][2];
    logic       m_chg  [2][2];
    logic [1:0] m_mprev[2][2];
    int         m_cnt  [2][2][4];

    function automatic logic [3:0] top_bit(input logic [3:0] v);
        for (int i = 3; i >= 0; i--)
            if (v[i]) return 4'(1 << i);
        return 4'd0;
    endfunction

    function automatic logic [3:0] socd(input logic [3:0] v);
        logic [3:0] r;
        r = v;
`ifdef JOYFILT_SOCD_EN
        if (v[1] && v[0]) r[1:0] = 2'b00;
        if (v[3] && v[2]) r[3:2] = 2'b00;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                m_s1[d][p] = 0; m_s2[d][p] = 0; m_deb[d][p] = 0; m_prev[d][p] = 0;
                m_mask[d][p] = 4'hF; m_cur[d][p] = 0; m_out[d][p] = 0;
                m_chg[d][p] = 0; m_mprev[d][p] = 0;
                for (int b = 0; b < 4; b++) m_cnt[d][p][b] = 0;
            end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                logic [3:0] raw, clean, allowed, fresh, nxt;
                logic [1:0] md;
                int ticks;
                raw   = dir_in[4*p +: 4];
                md    = mode[2*p +: 2];
                ticks = (d == 0) ? 0 : 4;
                clean = socd(m_deb[d][p]);
                nxt   = m_out[d][p];
                if (md != m_mprev[d][p]) begin
                    m_mask[d][p] = 4'hF;
                    m_cur[d][p]  = 4'd0;
                end else if (md == 2'd0) begin
                    nxt = clean;
                end else if (md == 2'd1) begin
                    fresh = clean & ~m_prev[d][p];
                    if ((clean & m_mask[d][p]) == 4'd0) m_mask[d][p] = 4'hF;
                    else if (fresh != 4'd0)             m_mask[d][p] = top_bit(fresh);
                    nxt = clean & m_mask[d][p];
                end else begin
                    allowed = (md == 2'd3) ? {2'b00, clean[1:0]} : clean;
                    fresh   = allowed & ~m_prev[d][p];
                    if ((allowed & m_cur[d][p]) != 4'd0) begin
                        if (fresh != 4'd0) m_cur[d][p] = top_bit(fresh);
                    end else begin
                        m_cur[d][p] = top_bit(allowed);
                    end
                    nxt = m_cur[d][p];
                end
                m_chg[d][p]   = (nxt != m_out[d][p]);
                m_out[d][p]   = nxt;
                m_prev[d][p]  = clean;
                m_mprev[d][p] = md;
                for (int b = 0; b < 4; b++) begin
                    if (ticks == 0) begin
                        m_deb[d][p][b] = m_s2[d][p][b];
                    end else if (m_s2[d][p][b] == m_deb[d][p][b]) begin
                        m_cnt[d][p][b] = 0;
                    end else if (ce) begin
                        if (m_cnt[d][p][b] == ticks - 1) begin
                            m_deb[d][p][b] = m_s2[d][p][b];
                            m_cnt[d][p][b] = 0;
                        end else begin
                            m_cnt[d][p][b]++;
                        end
                    end
                end
                m_s2[d][p] = m_s1[d][p];
                m_s1[d][p] = raw;
            end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: randomise player 1 (and player 0 when enabled), advance model, compare.
    task automatic tick();
        ce = (cyc % 10 == 9);
        if ($urandom_range(0, 2) == 0)  dir_in[7:4] = 4'($urandom);
        if ($urandom_range(0, 15) == 0) mode[3:2]   = 2'($urandom);
        if (rand_p0) begin
            if ($urandom_range(0, 2) == 0)  dir_in[3:0] = 4'($urandom);
            if ($urandom_range(0, 20) == 0) mode[1:0]   = 2'($urandom);
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        cyc++;
        #1;
        check("model_out_fast", out_fast, {m_out[0][1], m_out[0][0]});
        check("model_chg_fast", {6'd0, chg_fast}, {6'd0, m_chg[0][1], m_chg[0][0]});
        check("model_out_deb",  out_deb,  {m_out[1][1], m_out[1][0]});
        check("model_chg_deb",  {6'd0, chg_deb}, {6'd0, m_chg[1][1], m_chg[1][0]});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align_ce();
        for (int k = 0; k < 10 && (cyc % 10) != 0; k++) tick();
    endtask

    initial begin
        rst_n = 1'b1; ce = 1'b0; mode = '0; dir_in = '0;
        model_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_out_fast", out_fast, 8'h00);
        check("reset_chg_fast", {6'd0, chg_fast}, 8'h00);
        check("reset_out_deb",  out_deb,  8'h00);
        ticks(3);
        rst_n = 1'b1;

        // Latency with debounce bypassed, pass mode
        dir_in[3:0] = 4'b0010;
        ticks(3);
        check("lat3_p0", {4'd0, out_fast[3:0]}, 8'h00);
        tick();
        check("lat4_p0", {4'd0, out_fast[3:0]}, 8'h02);
        check("lat4_chg", {7'd0, chg_fast[0]}, 8'h01);
        tick();
        check("chg_pulse_end", {7'd0, chg_fast[0]}, 8'h00);

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("async_rst_out_fast", out_fast, 8'h00);
        check("async_rst_chg_fast", {6'd0, chg_fast}, 8'h00);
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        dir_in[3:0] = 4'b0000;
        ticks(50);

        // Debounce: 3-tick glitch rejected, 4 stable ticks accepted
        align_ce();
        dir_in[3:0] = 4'b0001;
        ticks(30);
        dir_in[3:0] = 4'b0000;
        ticks(20);
        check("deb_glitch3", {4'd0, out_deb[3:0]}, 8'h00);
        align_ce();
        dir_in[3:0] = 4'b0001;
        ticks(40);
        check("deb_tick4_pre", {4'd0, out_deb[3:0]}, 8'h00);
        tick();
        check("deb_tick4_acc", {4'd0, out_deb[3:0]}, 8'h01);

        // Mode 1: last-press
        dir_in[3:0] = 4'b0000; mode[1:0] = 2'd1;
        ticks(6);
        dir_in[3:0] = 4'b0001; ticks(5);
        check("m1_right", {4'd0, out_fast[3:0]}, 8'h01);
        dir_in[3:0] = 4'b1001; ticks(5);
        check("m1_add_up", {4'd0, out_fast[3:0]}, 8'h08);
        dir_in[3:0] = 4'b0001; ticks(5);
        check("m1_rel_up", {4'd0, out_fast[3:0]}, 8'h01);

        // Mode 2: strict 4-way
        dir_in[3:0] = 4'b0000; mode[1:0] = 2'd2;
        ticks(6);
        dir_in[3:0] = 4'b0110; ticks(5);
        check("m2_left_down", {4'd0, out_fast[3:0]}, 8'h04);
        dir_in[3:0] = 4'b0111; ticks(5);
        check("m2_add_right", {4'd0, out_fast[3:0]}, 8'h01);
        dir_in[3:0] = 4'b0110; ticks(5);
        check("m2_rel_right", {4'd0, out_fast[3:0]}, 8'h04);

        // Mode 3: 2-way horizontal, then switch to pass mid-hold
        dir_in[3:0] = 4'b0000; mode[1:0] = 2'd3;
        ticks(6);
        dir_in[3:0] = 4'b1000; ticks(5);
        check("m3_up_only", {4'd0, out_fast[3:0]}, 8'h00);
        dir_in[3:0] = 4'b1010; ticks(5);
        check("m3_up_left", {4'd0, out_fast[3:0]}, 8'h02);
        mode[1:0] = 2'd0;
        ticks(2);
        check("m3_to_pass", {4'd0, out_fast[3:0]}, 8'h0A);

        // Opposite pairs
        dir_in[3:0] = 4'b0000; ticks(5);
        dir_in[3:0] = 4'b0011; ticks(5);
`ifdef JOYFILT_SOCD_EN
        check("socd_lr", {4'd0, out_fast[3:0]}, 8'h00);
`else
        check("socd_lr", {4'd0, out_fast[3:0]}, 8'h03);
`endif
        dir_in[3:0] = 4'b0010; ticks(5);
        check("socd_rel_right", {4'd0, out_fast[3:0]}, 8'h02);

        // Randomised traffic on both players
        rand_p0 = 1;
        ticks(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
